// File: rtl/cds_pair_subtractor.sv
// CDS pair subtractor: pairs reset/signal ADC samples and queues (second - first) in a FWFT FIFO.
// Optional first-to-second wait timeout is compiled in with `define CDS_TIMEOUT_EN.
module cds_pair_subtractor #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cds_strobe,
    input  logic              cds_first,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W:0]   out_data,
    output logic [15:0]       drop_count,
    output logic [15:0]       ovf_count,
    output logic              timeout_flag
);
    localparam int unsigned DIFF_W = DATA_W + 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WAIT2 = 1'b1
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   first_reg;
    logic                diff_vld;
    logic [DIFF_W-1:0]   diff_reg;
    logic [DIFF_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;
    logic [15:0]         drop_cnt;
    logic [15:0]         ovf_cnt;
    logic                wait_expired;
    logic                pop;
    logic                push;
    logic                full;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef CDS_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              tmo_flag;

    // Expiry loses to a strobe arriving in the same cycle.
    assign wait_expired = (state == S_WAIT2) && !cds_strobe &&
                          (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
    assign timeout_flag = tmo_flag;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if (cds_strobe && cds_first) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT2 && !wait_expired) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (wait_expired) begin
                tmo_flag <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign wait_expired   = 1'b0;
    assign timeout_flag   = 1'b0;
`endif

    // Pairing FSM; the difference is staged one cycle before entering the FIFO.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            first_reg <= '0;
            diff_vld  <= 1'b0;
            diff_reg  <= '0;
            drop_cnt  <= '0;
        end else begin
            diff_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cds_strobe) begin
                        if (cds_first) begin
                            first_reg <= adc_data;
                            state     <= S_WAIT2;
                        end else begin
                            drop_cnt <= sat_inc(drop_cnt);
                        end
                    end
                end
                S_WAIT2: begin
                    if (cds_strobe) begin
                        if (cds_first) begin
                            first_reg <= adc_data;
                            drop_cnt  <= sat_inc(drop_cnt);
                        end else begin
                            diff_reg <= {1'b0, adc_data} - {1'b0, first_reg};
                            diff_vld <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end else if (wait_expired) begin
                        drop_cnt <= sat_inc(drop_cnt);
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign full = (count == CNT_W'(FIFO_DEPTH));
    assign pop  = out_valid && out_ready;
    assign push = diff_vld && (!full || pop);

    // First-word-fall-through FIFO; a full FIFO accepts a push only alongside a pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ovf_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= diff_reg;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (diff_vld && !push) begin
                ovf_cnt <= sat_inc(ovf_cnt);
            end
        end
    end

    assign out_valid  = (count != '0);
    assign out_data   = mem[rd_ptr];
    assign drop_count = drop_cnt;
    assign ovf_count  = ovf_cnt;

endmodule
